// File: rtl/mem_block_mover_pkg.sv
// Shared types and defaults for the block mover.
// FSM state encoding, mode encoding and default widths.
package mem_block_mover_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 9;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_block_mover_if.sv
// 8-bit data memory port shared by the mover and the memory.
// master: mem_read, mem_write, mem_address, mem_write_data out; mem_read_data in.
interface mem_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block COPY / FILL engine mastering the data memory port.
// Ports: clk, rst_n, start/mode/src_addr/dst_addr/length/fill_value, abort,
// busy, done, bytes_done; bus = memory port (master side).
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  bytes_done,
    mem_block_mover_if.master bus
);

    state_t            state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;

    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              accept;

    // abort beats a simultaneous start
    assign accept = start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                busy    = 1'b1;
                rd      = 1'b1;
                addr    = src_q;
                state_d = abort ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                busy  = 1'b1;
                // gated so an aborted cycle never commits a byte
                wr    = !abort;
                addr  = dst_q;
                wdata = (mode_q == MODE_FILL) ? fill_q : data_q;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q  <= mode;
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= length;
                        fill_q  <= fill_value;
                        count_q <= '0;
                    end
                end
                ST_READ: begin
                    if (!abort) begin
                        data_q <= bus.mem_read_data;
                        src_q  <= src_q + ADDR_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (!abort) begin
                        dst_q   <= dst_q + ADDR_W'(1);
                        count_q <= count_q + LEN_W'(1);
                        rem_q   <= rem_q - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bytes_done         = count_q;
    assign bus.mem_read       = rd;
    assign bus.mem_write      = wr;
    assign bus.mem_address    = addr;
    assign bus.mem_write_data = wdata;

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover with a 256x8 memory model.
// Directed cases plus randomized COPY/FILL transfers against a reference memory.
module tb_mem_block_mover;
    import mem_block_mover_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [8:0] length = '0;
    logic [7:0] fill_value = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [8:0] bytes_done;

    mem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_block_mover dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bytes_done (bytes_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // memory model and its reference copy
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address] : 8'h00;

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { int bytes; int lat; int acc; } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: writes, reads, done pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_read || bus.mem_write) begin
                checks++;
                if (bus.mem_read && bus.mem_write) begin
                    errors++;
                    $display("FAIL rd_wr_excl: both strobes high at cycle %0d", cyc);
                end
            end
            if (bus.mem_read) rd_cnt++;
            if (bus.mem_write) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexp: addr=%02h data=%02h, none expected",
                             bus.mem_address, bus.mem_write_data);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (bus.mem_address !== e.a || bus.mem_write_data !== e.d) begin
                        errors++;
                        $display("FAIL write: got %02h<=%02h, expected %02h<=%02h",
                                 bus.mem_address, bus.mem_write_data, e.a, e.d);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexp: done pulse at cycle %0d, none expected", cyc);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    if (int'(bytes_done) != e.bytes || (cyc - e.acc) != e.lat) begin
                        errors++;
                        $display("FAIL done: bytes=%0d lat=%0d, expected bytes=%0d lat=%0d",
                                 bytes_done, cyc - e.acc, e.bytes, e.lat);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // reference: strict forward byte order, first nwr bytes committed
    task automatic model(input bit m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] f, input int nwr);
        for (int i = 0; i < nwr; i++) begin
            logic [7:0] sa;
            logic [7:0] da;
            logic [7:0] v;
            sa = s + 8'(i);
            da = d + 8'(i);
            v = m ? f : ref_mem[sa];
            ref_mem[da] = v;
            wq.push_back('{a: da, d: v});
        end
    endtask

    task automatic issue(input bit m, input logic [7:0] s, input logic [7:0] d,
                         input int len, input logic [7:0] f, output int acc);
        @(posedge clk);
        #1;
        mode = m;
        src_addr = s;
        dst_addr = d;
        length = 9'(len);
        fill_value = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 700) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", n);
        end
    endtask

    task automatic run_full(input string name, input bit m, input logic [7:0] s,
                            input logic [7:0] d, input int len, input logic [7:0] f);
        int acc;
        int r0;
        int d0;
        int lat;
        lat = m ? len : 2 * len;
        model(m, s, d, f, len);
        r0 = rd_cnt;
        d0 = done_cnt;
        issue(m, s, d, len, f, acc);
        dq.push_back('{bytes: len, lat: lat, acc: acc});
        wait_done(d0);
        @(posedge clk);
        #1;
        check({name, "_bytes"}, int'(bytes_done), len);
        check({name, "_reads"}, rd_cnt - r0, m ? 0 : len);
        mem_compare({name, "_mem"});
    endtask

    initial begin
        int acc;
        int r0;
        rst_n = 1'b0;
        #1;
        check("reset_outs",
              int'({busy, done, bus.mem_read, bus.mem_write,
                    bus.mem_address, bus.mem_write_data, bytes_done}), 0);
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_full("fill4", MODE_FILL, 8'h00, 8'h10, 4, 8'hA5);
        poke(8'h04, 8'h12);
        poke(8'h05, 8'h34);
        run_full("copy2", MODE_COPY, 8'h04, 8'h80, 2, 8'h00);
        check("copy2_d0", int'(mem[8'h80]), 'h12);
        check("copy2_d1", int'(mem[8'h81]), 'h34);
        run_full("copy_wrap", MODE_COPY, 8'hFE, 8'h00, 3, 8'h00);
        run_full("len0_copy", MODE_COPY, 8'h20, 8'h30, 0, 8'h00);
        run_full("len0_fill", MODE_FILL, 8'h20, 8'h30, 0, 8'h77);
        run_full("overlap", MODE_COPY, 8'h40, 8'h41, 6, 8'h00);

        // abort in 3rd WRITE; a start while busy is ignored
        model(MODE_COPY, 8'h50, 8'hC0, 8'h00, 2);
        r0 = rd_cnt;
        issue(MODE_COPY, 8'h50, 8'hC0, 8, 8'h00, acc);
        @(posedge clk);
        #1;
        mode = MODE_FILL;
        dst_addr = 8'h00;
        length = 9'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_bytes", int'(bytes_done), 2);
        check("abort_reads", rd_cnt - r0, 3);
        repeat (4) @(posedge clk);
        #1;
        check("abort_hold", int'(bytes_done), 2);
        mem_compare("abort_mem");

        // abort and start together in IDLE: start dropped
        mode = MODE_FILL;
        dst_addr = 8'h90;
        length = 9'd5;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        check("abort_start_idle", int'(busy), 0);

        // async reset mid FILL after 4 writes
        model(MODE_FILL, 8'h00, 8'hA0, 8'h3C, 4);
        issue(MODE_FILL, 8'h00, 8'hA0, 10, 8'h3C, acc);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs",
              int'({busy, done, bus.mem_read, bus.mem_write,
                    bus.mem_address, bus.mem_write_data, bytes_done}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_compare("rst_mid_mem");
        run_full("after_rst", MODE_FILL, 8'h00, 8'hA0, 10, 8'h5A);

        for (int k = 0; k < 25; k++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 9));
            if (r == 0) len = 0;
            else if (r == 1) len = 256;
            else if (r == 2) len = 255;
            else len = int'($urandom_range(1, 40));
            run_full("rand", 1'($urandom), 8'($urandom), 8'($urandom),
                     len, 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("wq_empty", wq.size(), 0);
        check("dq_empty", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
